// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the width of the raw shift-amount input.
`timescale 1ns/1ps
package pipelined_shifter_pkg;

  // Operation select carried with every entry through the pipeline
  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  // Shift amount arrives as a full 32-bit unsigned value
  localparam int AMT_W = 32;

endpackage

// File: rtl/pipelined_shifter_shift_stage.sv
// One registered conditional-shift stage. When in_shift is set the operand is
// moved by DIST bit positions according to the operation; otherwise it passes
// through unchanged. All registers hold while advance is low.
`timescale 1ns/1ps
module shift_stage
  import pipelined_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             in_valid,
  input  logic             in_shift,
  input  op_t              in_op,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  output op_t              out_op,
  output logic [WIDTH-1:0] out_d
);

  logic [WIDTH-1:0] shifted;

  // Shift by DIST with the fill each operation requires
  always_comb begin
    shifted = in_d;
    if (in_shift) begin
      case (in_op)
        OP_SRL:  shifted = {{DIST{1'b0}}, in_d[WIDTH-1:DIST]};
        OP_SLL:  shifted = {in_d[WIDTH-1-DIST:0], {DIST{1'b0}}};
        OP_SRA:  shifted = {{DIST{in_d[WIDTH-1]}}, in_d[WIDTH-1:DIST]};
        default: shifted = {in_d[DIST-1:0], in_d[WIDTH-1:DIST]};
      endcase
    end
  end

  // Valid bit is the only state that must be cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid;
    end
  end

  // Payload moves with the pipeline and holds on stall
  always_ff @(posedge clk) begin
    if (advance) begin
      out_op <= in_op;
      out_d  <= shifted;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: an input register followed by LG conditional
// shift stages (distances 1, 2, 4, ...). The whole pipeline advances together
// whenever the output slot is empty or being drained.
`timescale 1ns/1ps
module pipelined_shifter
  import pipelined_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int LG   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  input  logic [AMT_W-1:0] in_s,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic [LG+1:0]    occupancy
);

  // Per-stage views; index 0 is the input register, LG is the output
  logic             valid_a [0:LG];
  logic [WIDTH-1:0] d_a     [0:LG];
  op_t              op_a    [0:LG];
  logic [TAG_W-1:0] tag_a   [0:LG];
  logic [LG-1:0]    amt_a   [0:LG-1];

  logic             advance;
  logic             in_xfer;
  logic             out_xfer;
  logic             oob;
  op_t              op_in;
  logic [WIDTH-1:0] d0_next;

  logic             s0_valid_reg;
  logic [WIDTH-1:0] s0_d_reg;
  op_t              s0_op_reg;
  logic [TAG_W-1:0] s0_tag_reg;
  logic [LG-1:0]    s0_amt_reg;
  logic [LG+1:0]    occ_reg;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign in_xfer  = in_valid && advance;
  assign out_xfer = out_valid && out_ready;
  assign op_in    = op_t'(in_op);
  assign oob      = (in_s >= AMT_W'(WIDTH));

  // Out-of-range logical/arithmetic shifts are resolved up front by loading
  // the final answer (zero or sign fill); every later stage then leaves it
  // unchanged whatever the low amount bits say. Rotates use amount mod WIDTH.
  always_comb begin
    d0_next = in_d;
    if (oob && op_in != OP_ROR) begin
      d0_next = (op_in == OP_SRA && in_d[WIDTH-1]) ? '1 : '0;
    end
  end

  // Input register valid bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_reg <= 1'b0;
    end else if (advance) begin
      s0_valid_reg <= in_valid;
    end
  end

  // Input register payload
  always_ff @(posedge clk) begin
    if (advance) begin
      s0_d_reg   <= d0_next;
      s0_op_reg  <= op_in;
      s0_tag_reg <= in_tag;
      s0_amt_reg <= in_s[LG-1:0];
    end
  end

  assign valid_a[0] = s0_valid_reg;
  assign d_a[0]     = s0_d_reg;
  assign op_a[0]    = s0_op_reg;
  assign tag_a[0]   = s0_tag_reg;
  assign amt_a[0]   = s0_amt_reg;

  // Stage gi shifts by 2^(gi-1); the amount is shifted down one bit per stage
  // so each stage always consults bit 0
  for (genvar gi = 1; gi <= LG; gi++) begin : g_stage
    logic [TAG_W-1:0] tag_reg;

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (gi - 1))
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .in_valid  (valid_a[gi-1]),
      .in_shift  (amt_a[gi-1][0]),
      .in_op     (op_a[gi-1]),
      .in_d      (d_a[gi-1]),
      .out_valid (valid_a[gi]),
      .out_op    (op_a[gi]),
      .out_d     (d_a[gi])
    );

    // Tag rides alongside the data unchanged
    always_ff @(posedge clk) begin
      if (advance) begin
        tag_reg <= tag_a[gi-1];
      end
    end
    assign tag_a[gi] = tag_reg;

    if (gi < LG) begin : g_amt
      logic [LG-1:0] amt_reg;

      // Remaining amount bits for the following stages
      always_ff @(posedge clk) begin
        if (advance) begin
          amt_reg <= amt_a[gi-1] >> 1;
        end
      end
      assign amt_a[gi] = amt_reg;
    end
  end

  // Occupancy tracks accepted-but-not-delivered operations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign out_valid = valid_a[LG];
  assign out_y     = d_a[LG];
  assign out_tag   = tag_a[LG];
  assign occupancy = occ_reg;

endmodule
